pzcorebus_upsizer_data_packer: RTL and testbench
================================================

Name: pzcorebus_upsizer_data_packer

Overview:
Parametrised write-data packer for the next-generation corebus upsizer. It takes one command descriptor per burst (start lane, beat count), then packs narrow slave-side write beats into wide master-side beats. Handles arbitrary start-lane offset and partial first/last wide words via byte-enable masking, and runs at any power-of-two ratio including 1 (pass-through). It sits between the command/data aligner and the master FIFO, with an internal output buffer of configurable depth.

Parameters:
SLAVE_DATA_WIDTH, 32, narrow data width in bits; multiple of 8.
RATIO, 4, wide/narrow width ratio; must be 1, 2, 4 or 8.
LENGTH_WIDTH, 8, width of the burst-length field.
OUTPUT_DEPTH, 2, output buffer entries; 1 to 4.
MASTER_DATA_WIDTH, SLAVE_DATA_WIDTH*RATIO, derived; not overridable.
LANE_WIDTH, max(1,$clog2(RATIO)), derived.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid&&ready
i_cmd_offset  in  LANE_WIDTH  start lane of first beat (ignored when RATIO=1)
i_cmd_length  in  LENGTH_WIDTH  narrow beats minus 1
i_data_valid  in  1  narrow beat valid
o_data_ready  out  1  narrow beat accepted when valid&&ready
i_data  in  SLAVE_DATA_WIDTH  narrow data
i_byte_enable  in  SLAVE_DATA_WIDTH/8  narrow byte enables
i_data_last  in  1  upstream last marker (checked only)
o_data_valid  out  1  wide beat valid
i_data_ready  in  1  wide beat accepted when valid&&ready
o_data  out  MASTER_DATA_WIDTH  wide data
o_byte_enable  out  MASTER_DATA_WIDTH/8  wide byte enables
o_data_last  out  1  final wide beat of burst
o_last_mismatch  out  1  one-cycle pulse: i_data_last disagrees with internal count
o_busy  out  1  burst in progress or buffer non-empty

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is asynchronous and active-high; all state clears immediately on assertion.
- Reset values: o_cmd_ready=0 while i_rst is high, then 1 from the first cycle after release. o_data_ready=0, o_data_valid=0, o_data=0, o_byte_enable=0, o_data_last=0, o_last_mismatch=0, o_busy=0.
- State machine:
  - IDLE: o_cmd_ready=1, o_data_ready=0. Command handshake loads lane=i_cmd_offset, remaining=i_cmd_length, and clears the accumulator (data=0, be=0). Next state PACK.
  - PACK: o_cmd_ready=0. o_data_ready=1 unless the buffer is full (count==OUTPUT_DEPTH) and the pending beat would complete a wide word; otherwise 1.
- Each accepted narrow beat writes i_data and i_byte_enable into lane `lane` of the accumulator, then lane increments mod RATIO and remaining decrements.
- Wide word completion occurs when lane==RATIO-1 or remaining==0 on the accepted beat:
  - Push {accumulator merged with current beat, last=(remaining==0)} into the buffer in the same cycle.
  - Clear the accumulator.
  - Lanes never written carry data 0 and byte enable 0.
- Final beat (remaining==0): state returns to IDLE. This gives one bubble cycle between bursts.
- Latency: a wide beat is presented on o_data_valid in the cycle after the completing narrow beat is accepted, provided the buffer was empty.
- Output buffer: FIFO of OUTPUT_DEPTH entries; outputs come from the head entry (registered).
  - Push and pop in the same cycle are allowed when full.
  - o_data_valid = buffer non-empty.
  - Ordering is strictly preserved.
- Last check: on every accepted beat, if i_data_last != (remaining==0), o_last_mismatch pulses in the next cycle. Packing always follows the internal count; i_data_last never alters framing.
- RATIO=1: offset is ignored, every beat completes a word, o_byte_enable equals i_byte_enable, and latency is 1 cycle.
- Boundaries:
  - Offset plus length wraps across any number of wide words.
  - Length 0 emits exactly one wide word.
  - Maximum length 2^LENGTH_WIDTH beats must be supported without counter overflow.
- o_busy = (state==PACK) || buffer non-empty.
- Reset mid-burst: accumulator, buffer and counters are discarded; no partial word is emitted after release.

Test Plan:
- RATIO=4, width 32, offset 0, length 3, beats 0x11111111..0x44444444, be 0xF each -> one wide beat 0x44444444_33333333_22222222_11111111, be 0xFFFF, last=1, one cycle after the 4th accept.
- Offset 3, length 1, beats 0xAAAAAAAA then 0xBBBBBBBB -> wide beat 1: lane3=0xAAAAAAAA, be 0xF000, last=0; wide beat 2: lane0=0xBBBBBBBB, be 0x000F, last=1.
- OUTPUT_DEPTH=2, i_data_ready=0, offset 0, length 15 -> two wide beats buffered, then o_data_ready drops on the beat that would complete the 3rd word; after i_data_ready=1 all 4 words drain in order, the 4th with last=1.
- Offset 1, length 0, i_data_last=0, beat 0xCAFEF00D -> one wide beat with lane1=0xCAFEF00D, be 0x00F0, last=1; o_last_mismatch pulses one cycle.
- Assert i_rst after 2 of 4 beats -> all outputs 0 immediately; after release o_cmd_ready=1, o_busy=0, and no wide beat appears.
- RATIO=1, length 2, beats with be 0xF, 0x3, 0xC -> three wide beats with identical data and be, last only on the third, one-cycle latency each.

Source files
------------

// File: rtl/pzcorebus_upsizer_data_packer.sv
// Write-data packer for the corebus upsizer: narrow slave beats are packed into
// wide master beats at a start-lane offset, buffered in a small output FIFO.
module pzcorebus_upsizer_data_packer #(
  parameter int SLAVE_DATA_WIDTH  = 32,
  parameter int RATIO             = 4,
  parameter int LENGTH_WIDTH      = 8,
  parameter int OUTPUT_DEPTH      = 2,
  localparam int MASTER_DATA_WIDTH = SLAVE_DATA_WIDTH * RATIO,
  localparam int LANE_WIDTH        = (RATIO > 1) ? $clog2(RATIO) : 1
)(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic [LANE_WIDTH-1:0]          i_cmd_offset,
  input  logic [LENGTH_WIDTH-1:0]        i_cmd_length,
  input  logic                           i_data_valid,
  output logic                           o_data_ready,
  input  logic [SLAVE_DATA_WIDTH-1:0]    i_data,
  input  logic [SLAVE_DATA_WIDTH/8-1:0]  i_byte_enable,
  input  logic                           i_data_last,
  output logic                           o_data_valid,
  input  logic                           i_data_ready,
  output logic [MASTER_DATA_WIDTH-1:0]   o_data,
  output logic [MASTER_DATA_WIDTH/8-1:0] o_byte_enable,
  output logic                           o_data_last,
  output logic                           o_last_mismatch,
  output logic                           o_busy
);
  localparam int SBE_WIDTH = SLAVE_DATA_WIDTH / 8;
  localparam int MBE_WIDTH = MASTER_DATA_WIDTH / 8;
  localparam int PTR_WIDTH = (OUTPUT_DEPTH > 1) ? $clog2(OUTPUT_DEPTH) : 1;
  localparam int CNT_WIDTH = $clog2(OUTPUT_DEPTH + 1);
  localparam logic [LANE_WIDTH-1:0] LANE_LAST = LANE_WIDTH'(RATIO - 1);
  localparam logic [PTR_WIDTH-1:0]  PTR_LAST  = PTR_WIDTH'(OUTPUT_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(OUTPUT_DEPTH);

  typedef enum logic {
    IDLE,
    PACK
  } state_t;

  state_t                       state;
  logic                         cmd_ready_q;
  logic [LANE_WIDTH-1:0]        lane;
  logic [LENGTH_WIDTH-1:0]      remaining;
  logic [MASTER_DATA_WIDTH-1:0] acc_data;
  logic [MBE_WIDTH-1:0]         acc_be;
  logic                         mismatch_q;

  logic [MASTER_DATA_WIDTH-1:0] mem_data [OUTPUT_DEPTH];
  logic [MBE_WIDTH-1:0]         mem_be   [OUTPUT_DEPTH];
  logic                         mem_last [OUTPUT_DEPTH];
  logic [PTR_WIDTH-1:0]         head;
  logic [PTR_WIDTH-1:0]         tail;
  logic [CNT_WIDTH-1:0]         count;

  logic                         last_beat;
  logic                         word_done;
  logic                         data_accept;
  logic                         buf_full;
  logic                         push;
  logic                         pop;
  logic [LANE_WIDTH-1:0]        lane_next;
  logic [MASTER_DATA_WIDTH-1:0] word_data;
  logic [MBE_WIDTH-1:0]         word_be;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign last_beat   = (remaining == '0);
  assign word_done   = last_beat || (lane == LANE_LAST);
  assign buf_full    = (count == CNT_FULL);
  assign pop         = (count != '0) && i_data_ready;
  // A beat that would complete a word may still enter a full buffer when the head drains this cycle.
  assign o_data_ready = (state == PACK) && !(buf_full && word_done && !pop);
  assign data_accept = i_data_valid && o_data_ready;
  assign push        = data_accept && word_done;
  assign lane_next   = (RATIO == 1) ? '0 : lane + 1'b1;

  always_comb begin
    word_data = acc_data;
    word_be   = acc_be;
    for (int unsigned l = 0; l < RATIO; l++) begin
      if (lane == LANE_WIDTH'(l)) begin
        word_data[l*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH] = i_data;
        word_be[l*SBE_WIDTH +: SBE_WIDTH]                 = i_byte_enable;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      lane        <= '0;
      remaining   <= '0;
      acc_data    <= '0;
      acc_be      <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      mismatch_q <= data_accept && (i_data_last != last_beat);
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (i_cmd_valid && cmd_ready_q) begin
            state       <= PACK;
            cmd_ready_q <= 1'b0;
            lane        <= (RATIO == 1) ? '0 : i_cmd_offset;
            remaining   <= i_cmd_length;
            acc_data    <= '0;
            acc_be      <= '0;
          end
        end
        PACK: begin
          if (data_accept) begin
            lane      <= lane_next;
            remaining <= remaining - 1'b1;
            if (word_done) begin
              acc_data <= '0;
              acc_be   <= '0;
            end else begin
              acc_data <= word_data;
              acc_be   <= word_be;
            end
            if (last_beat) begin
              state       <= IDLE;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < OUTPUT_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_be[i]   <= '0;
        mem_last[i] <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_data[tail] <= word_data;
        mem_be[tail]   <= word_be;
        mem_last[tail] <= last_beat;
        tail           <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_cmd_ready     = cmd_ready_q;
  assign o_data_valid    = (count != '0);
  assign o_data          = mem_data[head];
  assign o_byte_enable   = mem_be[head];
  assign o_data_last     = mem_last[head];
  assign o_last_mismatch = mismatch_q;
  assign o_busy          = (state == PACK) || (count != '0);

endmodule

// File: tb/tb_pzcorebus_upsizer_data_packer.sv
// Directed bench for the upsizer data packer: a RATIO=4 instance and a RATIO=1 pass-through instance.
module tb_pzcorebus_upsizer_data_packer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_offset = '0;
  logic [7:0]   cmd_length = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [3:0]   in_be = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [15:0]  out_be;
  logic         out_last;
  logic         mismatch;
  logic         busy;

  logic         c1_cmd_valid = 1'b0;
  logic         c1_cmd_ready;
  logic [0:0]   c1_cmd_offset = '0;
  logic [7:0]   c1_cmd_length = '0;
  logic         c1_in_valid = 1'b0;
  logic         c1_in_ready;
  logic [31:0]  c1_in_data = '0;
  logic [3:0]   c1_in_be = '0;
  logic         c1_in_last = 1'b0;
  logic         c1_out_valid;
  logic         c1_out_ready = 1'b1;
  logic [31:0]  c1_out_data;
  logic [3:0]   c1_out_be;
  logic         c1_out_last;
  logic         c1_mismatch;
  logic         c1_busy;

  int errors = 0;
  int checks = 0;

  logic [127:0] mq_data [$];
  logic [15:0]  mq_be   [$];
  logic         mq_last [$];

  always #5 clk = ~clk;

  pzcorebus_upsizer_data_packer #(
    .SLAVE_DATA_WIDTH(32), .RATIO(4), .LENGTH_WIDTH(8), .OUTPUT_DEPTH(2)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_offset(cmd_offset), .i_cmd_length(cmd_length),
    .i_data_valid(in_valid), .o_data_ready(in_ready),
    .i_data(in_data), .i_byte_enable(in_be), .i_data_last(in_last),
    .o_data_valid(out_valid), .i_data_ready(out_ready),
    .o_data(out_data), .o_byte_enable(out_be), .o_data_last(out_last),
    .o_last_mismatch(mismatch), .o_busy(busy)
  );

  pzcorebus_upsizer_data_packer #(
    .SLAVE_DATA_WIDTH(32), .RATIO(1), .LENGTH_WIDTH(8), .OUTPUT_DEPTH(2)
  ) u_dut_r1 (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(c1_cmd_valid), .o_cmd_ready(c1_cmd_ready),
    .i_cmd_offset(c1_cmd_offset), .i_cmd_length(c1_cmd_length),
    .i_data_valid(c1_in_valid), .o_data_ready(c1_in_ready),
    .i_data(c1_in_data), .i_byte_enable(c1_in_be), .i_data_last(c1_in_last),
    .o_data_valid(c1_out_valid), .i_data_ready(c1_out_ready),
    .o_data(c1_out_data), .o_byte_enable(c1_out_be), .o_data_last(c1_out_last),
    .o_last_mismatch(c1_mismatch), .o_busy(c1_busy)
  );

  // Record every wide beat that will be popped at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mq_data.push_back(out_data);
      mq_be.push_back(out_be);
      mq_last.push_back(out_last);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] off, input logic [7:0] len);
    int n = 0;
    cmd_valid  = 1'b1;
    cmd_offset = off;
    cmd_length = len;
    #1;
    while (!cmd_ready && n < 50) begin cycle(); n++; end
    chk("cmd_wait", (n < 50), 1'b1);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] be, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_be    = be;
    in_last  = last;
    #1;
    while (!in_ready && n < 50) begin cycle(); n++; end
    chk("beat_wait", (n < 50), 1'b1);
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_word;
    int n;

    // Reset state
    cycle();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_data_ready", in_ready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 128'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    cycle();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    // Aligned full word
    out_ready = 1'b1;
    send_cmd(2'd0, 8'd3);
    chk("t1_busy", busy, 1'b1);
    beat(32'h11111111, 4'hF, 1'b0);
    beat(32'h22222222, 4'hF, 1'b0);
    beat(32'h33333333, 4'hF, 1'b0);
    chk("t1_no_early_valid", out_valid, 1'b0);
    beat(32'h44444444, 4'hF, 1'b1);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 128'h44444444_33333333_22222222_11111111);
    chk("t1_be", out_be, 16'hFFFF);
    chk("t1_last", out_last, 1'b1);
    chk("t1_mismatch", mismatch, 1'b0);
    cycle();
    chk("t1_drained", out_valid, 1'b0);
    chk("t1_idle", busy, 1'b0);

    // Offset 3 wrapping into a second word
    send_cmd(2'd3, 8'd1);
    beat(32'hAAAAAAAA, 4'hF, 1'b0);
    chk("t2_w0_valid", out_valid, 1'b1);
    chk("t2_w0_data", out_data, {32'hAAAAAAAA, 96'h0});
    chk("t2_w0_be", out_be, 16'hF000);
    chk("t2_w0_last", out_last, 1'b0);
    beat(32'hBBBBBBBB, 4'hF, 1'b1);
    chk("t2_w1_valid", out_valid, 1'b1);
    chk("t2_w1_data", out_data, {96'h0, 32'hBBBBBBBB});
    chk("t2_w1_be", out_be, 16'h000F);
    chk("t2_w1_last", out_last, 1'b1);
    cycle();

    // Length 0 at offset 1 with a wrong upstream last marker
    send_cmd(2'd1, 8'd0);
    beat(32'hCAFEF00D, 4'hF, 1'b0);
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_data", out_data, {64'h0, 32'hCAFEF00D, 32'h0});
    chk("t4_be", out_be, 16'h00F0);
    chk("t4_last", out_last, 1'b1);
    chk("t4_mismatch_pulse", mismatch, 1'b1);
    cycle();
    chk("t4_mismatch_clear", mismatch, 1'b0);
    chk("t4_drained", out_valid, 1'b0);

    // Backpressure with a full output buffer
    out_ready = 1'b0;
    mq_data.delete(); mq_be.delete(); mq_last.delete();
    send_cmd(2'd0, 8'd15);
    for (int i = 1; i <= 11; i++) beat({4{8'(i)}}, 4'hF, 1'b0);
    chk("t3_head_valid", out_valid, 1'b1);
    chk("t3_head_data", out_data, 128'h04040404_03030303_02020202_01010101);
    in_valid = 1'b1;
    in_data  = 32'h0C0C0C0C;
    in_be    = 4'hF;
    #1;
    cycle(); cycle();
    chk("t3_stall_ready", in_ready, 1'b0);
    chk("t3_stall_busy", busy, 1'b1);
    chk("t3_nothing_popped", mq_data.size(), 0);
    out_ready = 1'b1;
    for (int i = 12; i <= 16; i++) beat({4{8'(i)}}, 4'hF, (i == 16));
    n = 0;
    while (mq_data.size() < 4 && n < 20) begin cycle(); n++; end
    cycle();
    chk("t3_word_count", mq_data.size(), 4);
    for (int k = 0; k < 4; k++) begin
      exp_word = '0;
      for (int j = 0; j < 4; j++) exp_word[j*32 +: 32] = {4{8'(4*k + j + 1)}};
      if (k < mq_data.size()) begin
        chk($sformatf("t3_w%0d_data", k), mq_data[k], exp_word);
        chk($sformatf("t3_w%0d_be", k), mq_be[k], 16'hFFFF);
        chk($sformatf("t3_w%0d_last", k), mq_last[k], (k == 3));
      end
    end
    chk("t3_idle", busy, 1'b0);

    // Reset in the middle of a burst
    mq_data.delete(); mq_be.delete(); mq_last.delete();
    send_cmd(2'd0, 8'd3);
    beat(32'h55555555, 4'hF, 1'b0);
    beat(32'h66666666, 4'hF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_cmd_ready", cmd_ready, 1'b0);
    chk("t5_data_ready", in_ready, 1'b0);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_data", out_data, 128'h0);
    chk("t5_be", out_be, 16'h0);
    chk("t5_last", out_last, 1'b0);
    chk("t5_mismatch", mismatch, 1'b0);
    chk("t5_busy", busy, 1'b0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("t5_post_cmd_ready", cmd_ready, 1'b1);
    chk("t5_post_busy", busy, 1'b0);
    repeat (6) cycle();
    chk("t5_no_output", mq_data.size(), 0);
    chk("t5_no_valid", out_valid, 1'b0);

    // RATIO=1 pass-through
    c1_cmd_valid  = 1'b1;
    c1_cmd_length = 8'd2;
    #1;
    n = 0;
    while (!c1_cmd_ready && n < 50) begin cycle(); n++; end
    chk("t6_cmd_wait", (n < 50), 1'b1);
    cycle();
    c1_cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] d;
      logic [3:0]  be;
      d  = (k == 0) ? 32'h12345678 : (k == 1) ? 32'h9ABCDEF0 : 32'h0F0F0F0F;
      be = (k == 0) ? 4'hF : (k == 1) ? 4'h3 : 4'hC;
      c1_in_valid = 1'b1;
      c1_in_data  = d;
      c1_in_be    = be;
      c1_in_last  = (k == 2);
      #1;
      n = 0;
      while (!c1_in_ready && n < 50) begin cycle(); n++; end
      chk("t6_beat_wait", (n < 50), 1'b1);
      cycle();
      c1_in_valid = 1'b0;
      c1_in_last  = 1'b0;
      chk($sformatf("t6_b%0d_valid", k), c1_out_valid, 1'b1);
      chk($sformatf("t6_b%0d_data", k), c1_out_data, d);
      chk($sformatf("t6_b%0d_be", k), c1_out_be, be);
      chk($sformatf("t6_b%0d_last", k), c1_out_last, (k == 2));
    end
    cycle();
    chk("t6_drained", c1_out_valid, 1'b0);
    chk("t6_mismatch", c1_mismatch, 1'b0);
    chk("t6_idle", c1_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
